// File: rtl/saxi_rr_arbiter.sv
// saxi_rr_arbiter: round-robin arbiter that merges NUM_IN AXI-stream requesters
// onto one registered AXI-stream output tagged with the source index.
// A grant lasts up to MAX_BURST beats. It ends early if the granted requester
// drops TVALID. Each IDLE arbitration cycle produces one bubble.
//
// Ports:
//   ACLK        clock, all logic on the rising edge
//   ARESET      synchronous active-high reset
//   TVALID_IN   per-requester valid
//   TDATA_IN    per-requester data, requester i in [i*DATA_W +: DATA_W]
//   TREADY_IN   per-requester ready (combinational from state and TREADY_OUT)
//   TVALID_OUT  shared-stream valid (registered)
//   TDATA_OUT   shared-stream data (registered)
//   TID_OUT     index of the requester that produced TDATA_OUT (registered)
//   TREADY_OUT  downstream ready
module saxi_rr_arbiter #(
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned ID_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [NUM_IN-1:0]        TVALID_IN,
  input  logic [NUM_IN*DATA_W-1:0] TDATA_IN,
  output logic [NUM_IN-1:0]        TREADY_IN,
  output logic                     TVALID_OUT,
  output logic [DATA_W-1:0]        TDATA_OUT,
  output logic [ID_W-1:0]          TID_OUT,
  input  logic                     TREADY_OUT
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  gnt;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] beat_cnt;

  logic              out_free;
  logic              gnt_valid;
  logic [DATA_W-1:0] gnt_data;
  logic              accept;
  logic              sel_found;
  logic [ID_W-1:0]   sel_idx;
  logic [ID_W-1:0]   ptr_next;

  // Output register can take a beat when empty or being popped this cycle
  assign out_free = !TVALID_OUT || TREADY_OUT;

  // Select the granted requester's valid/data and drive its ready
  always_comb begin
    gnt_valid = 1'b0;
    gnt_data  = '0;
    TREADY_IN = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (gnt == ID_W'(i)) begin
        gnt_valid = TVALID_IN[i];
        gnt_data  = TDATA_IN[i*DATA_W +: DATA_W];
        if (state == GRANT && out_free) begin
          TREADY_IN[i] = 1'b1;
        end
      end
    end
  end

  assign accept = (state == GRANT) && gnt_valid && out_free;

  // First valid requester scanning from ptr upward with wrap at NUM_IN
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < int'(NUM_IN); k++) begin
      int idx;
      idx = (int'(ptr) + k) % int'(NUM_IN);
      if (!sel_found && TVALID_IN[idx]) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'(idx);
      end
    end
  end

  // Explicit wrap keeps ptr inside 0..NUM_IN-1 for non-power-of-two NUM_IN
  assign ptr_next = (int'(gnt) == int'(NUM_IN) - 1) ? '0 : gnt + ID_W'(1);

  // Arbitration FSM and output register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= IDLE;
      gnt        <= '0;
      ptr        <= '0;
      beat_cnt   <= '0;
      TVALID_OUT <= 1'b0;
      TDATA_OUT  <= '0;
      TID_OUT    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            gnt      <= sel_idx;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (beat_cnt == LAST_BEAT) begin
              state <= IDLE;
              ptr   <= ptr_next;
            end
          end else if (!gnt_valid) begin
            // Requester went idle: release without waiting for the burst to finish
            state <= IDLE;
            ptr   <= ptr_next;
          end
        end
        default: state <= IDLE;
      endcase

      // Reload on accept; otherwise drain once the downstream takes the beat
      if (accept) begin
        TVALID_OUT <= 1'b1;
        TDATA_OUT  <= gnt_data;
        TID_OUT    <= gnt;
      end else if (TVALID_OUT && TREADY_OUT) begin
        TVALID_OUT <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_saxi_rr_arbiter.sv
// Testbench for saxi_rr_arbiter (NUM_IN=4, DATA_W=32, MAX_BURST=4).
// Table rows give the inputs for one cycle, TREADY_IN expected before the edge,
// and the registered outputs expected after the edge. A hand-written sequence
// covers four requesters that stay valid the whole time.
module tb_saxi_rr_arbiter;

  logic         ACLK;
  logic         ARESET;
  logic [3:0]   TVALID_IN;
  logic [127:0] TDATA_IN;
  logic [3:0]   TREADY_IN;
  logic         TVALID_OUT;
  logic [31:0]  TDATA_OUT;
  logic [1:0]   TID_OUT;
  logic         TREADY_OUT;

  saxi_rr_arbiter #(
    .NUM_IN   (4),
    .DATA_W   (32),
    .MAX_BURST(4)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .TVALID_IN (TVALID_IN),
    .TDATA_IN  (TDATA_IN),
    .TREADY_IN (TREADY_IN),
    .TVALID_OUT(TVALID_OUT),
    .TDATA_OUT (TDATA_OUT),
    .TID_OUT   (TID_OUT),
    .TREADY_OUT(TREADY_OUT)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  typedef struct {
    logic        rst;
    logic [3:0]  tv;
    logic [31:0] d0, d1, d2, d3;
    logic        tro;
    logic [3:0]  erdy;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  eid;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(input logic rst, input logic [3:0] tv,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic tro, input logic [3:0] erdy,
                              input logic ev, input logic [31:0] ed,
                              input logic [1:0] eid);
    vec_t v;
    v.rst = rst; v.tv = tv; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
    v.tro = tro; v.erdy = erdy; v.ev = ev; v.ed = ed; v.eid = eid;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Called at posedge+1; leaves time at the next posedge+1
  task automatic apply(input vec_t v, input int idx);
    ARESET     = v.rst;
    TVALID_IN  = v.tv;
    TDATA_IN   = {v.d3, v.d2, v.d1, v.d0};
    TREADY_OUT = v.tro;
    #4;
    chk($sformatf("row%0d tready_in", idx), 32'(TREADY_IN), 32'(v.erdy));
    @(posedge ACLK);
    #1;
    chk($sformatf("row%0d tvalid_out", idx), 32'(TVALID_OUT), 32'(v.ev));
    chk($sformatf("row%0d tdata_out", idx), TDATA_OUT, v.ed);
    chk($sformatf("row%0d tid_out", idx), 32'(TID_OUT), 32'(v.eid));
  endtask

  initial begin
    int         cnt [4];
    logic [3:0] hs;
    logic       exp_v;
    int         b, j, r, n, sum;

    // Single requester 0, six beats: burst of 4, bubble, then 2
    vecs.push_back(mk(1'b0, 4'b0001, 32'hA0, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0000, 1'b0, 32'h00, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0001, 32'hA0, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0001, 1'b1, 32'hA0, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0001, 32'hA1, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0001, 1'b1, 32'hA1, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0001, 32'hA2, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0001, 1'b1, 32'hA2, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0001, 32'hA3, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0001, 1'b1, 32'hA3, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0001, 32'hA4, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0000, 1'b0, 32'hA3, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0001, 32'hA4, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0001, 1'b1, 32'hA4, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0001, 32'hA5, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0001, 1'b1, 32'hA5, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0000, 32'h00, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0001, 1'b0, 32'hA5, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0000, 32'h00, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0000, 1'b0, 32'hA5, 2'd0));
    // Reset from IDLE clears the output register
    vecs.push_back(mk(1'b1, 4'b0000, 32'h00, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0000, 1'b0, 32'h00, 2'd0));
    // Wrap-around: one beat from 2 leaves ptr=3, then 0 and 1 are served in order
    vecs.push_back(mk(1'b0, 4'b0100, 32'h0, 32'h0, 32'h2200, 32'h0, 1'b1, 4'b0000, 1'b0, 32'h0000, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0100, 32'h0, 32'h0, 32'h2200, 32'h0, 1'b1, 4'b0100, 1'b1, 32'h2200, 2'd2));
    vecs.push_back(mk(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0100, 1'b0, 32'h2200, 2'd2));
    vecs.push_back(mk(1'b0, 4'b0011, 32'h300, 32'h310, 32'h0, 32'h0, 1'b1, 4'b0000, 1'b0, 32'h2200, 2'd2));
    vecs.push_back(mk(1'b0, 4'b0011, 32'h300, 32'h310, 32'h0, 32'h0, 1'b1, 4'b0001, 1'b1, 32'h300, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0010, 32'h0, 32'h310, 32'h0, 32'h0, 1'b1, 4'b0001, 1'b0, 32'h300, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0010, 32'h0, 32'h310, 32'h0, 32'h0, 1'b1, 4'b0000, 1'b0, 32'h300, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0010, 32'h0, 32'h310, 32'h0, 32'h0, 1'b1, 4'b0010, 1'b1, 32'h310, 2'd1));
    vecs.push_back(mk(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0010, 1'b0, 32'h310, 2'd1));
    // Backpressure: TREADY_OUT low 5 cycles mid-burst of requester 3, 0 waiting
    vecs.push_back(mk(1'b0, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h3300, 1'b1, 4'b0000, 1'b0, 32'h310, 2'd1));
    vecs.push_back(mk(1'b0, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h3300, 1'b1, 4'b1000, 1'b1, 32'h3300, 2'd3));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1'b0, 4'b1001, 32'h400, 32'h0, 32'h0, 32'h3301, 1'b0, 4'b0000, 1'b1, 32'h3300, 2'd3));
    vecs.push_back(mk(1'b0, 4'b1001, 32'h400, 32'h0, 32'h0, 32'h3301, 1'b1, 4'b1000, 1'b1, 32'h3301, 2'd3));
    vecs.push_back(mk(1'b0, 4'b1001, 32'h400, 32'h0, 32'h0, 32'h3302, 1'b1, 4'b1000, 1'b1, 32'h3302, 2'd3));
    vecs.push_back(mk(1'b0, 4'b0001, 32'h400, 32'h0, 32'h0, 32'h0, 1'b1, 4'b1000, 1'b0, 32'h3302, 2'd3));
    vecs.push_back(mk(1'b0, 4'b0001, 32'h400, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0000, 1'b0, 32'h3302, 2'd3));
    vecs.push_back(mk(1'b0, 4'b0001, 32'h400, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0001, 1'b1, 32'h400, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0001, 1'b0, 32'h400, 2'd0));
    // Requester 1 drops after 2 beats; 3 follows one bubble later with a full burst
    vecs.push_back(mk(1'b0, 4'b1010, 32'h0, 32'h510, 32'h0, 32'h530, 1'b1, 4'b0000, 1'b0, 32'h400, 2'd0));
    vecs.push_back(mk(1'b0, 4'b1010, 32'h0, 32'h510, 32'h0, 32'h530, 1'b1, 4'b0010, 1'b1, 32'h510, 2'd1));
    vecs.push_back(mk(1'b0, 4'b1010, 32'h0, 32'h511, 32'h0, 32'h530, 1'b1, 4'b0010, 1'b1, 32'h511, 2'd1));
    vecs.push_back(mk(1'b0, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h530, 1'b1, 4'b0010, 1'b0, 32'h511, 2'd1));
    vecs.push_back(mk(1'b0, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h530, 1'b1, 4'b0000, 1'b0, 32'h511, 2'd1));
    vecs.push_back(mk(1'b0, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h530, 1'b1, 4'b1000, 1'b1, 32'h530, 2'd3));
    vecs.push_back(mk(1'b0, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h531, 1'b1, 4'b1000, 1'b1, 32'h531, 2'd3));
    vecs.push_back(mk(1'b0, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h532, 1'b1, 4'b1000, 1'b1, 32'h532, 2'd3));
    vecs.push_back(mk(1'b0, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h533, 1'b1, 4'b1000, 1'b1, 32'h533, 2'd3));
    vecs.push_back(mk(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0000, 1'b0, 32'h533, 2'd3));
    // Move ptr to 2, then reset mid-burst of requester 2: output discarded, ptr back to 0
    vecs.push_back(mk(1'b0, 4'b0010, 32'h0, 32'h610, 32'h0, 32'h0, 1'b1, 4'b0000, 1'b0, 32'h533, 2'd3));
    vecs.push_back(mk(1'b0, 4'b0010, 32'h0, 32'h610, 32'h0, 32'h0, 1'b1, 4'b0010, 1'b1, 32'h610, 2'd1));
    vecs.push_back(mk(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0010, 1'b0, 32'h610, 2'd1));
    vecs.push_back(mk(1'b0, 4'b0100, 32'h0, 32'h0, 32'h620, 32'h0, 1'b1, 4'b0000, 1'b0, 32'h610, 2'd1));
    vecs.push_back(mk(1'b0, 4'b0100, 32'h0, 32'h0, 32'h620, 32'h0, 1'b1, 4'b0100, 1'b1, 32'h620, 2'd2));
    vecs.push_back(mk(1'b1, 4'b0101, 32'h600, 32'h0, 32'h621, 32'h0, 1'b1, 4'b0100, 1'b0, 32'h0, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0101, 32'h600, 32'h0, 32'h621, 32'h0, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0101, 32'h600, 32'h0, 32'h621, 32'h0, 1'b1, 4'b0001, 1'b1, 32'h600, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0100, 32'h0, 32'h0, 32'h621, 32'h0, 1'b1, 4'b0001, 1'b0, 32'h600, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0100, 32'h0, 32'h0, 32'h621, 32'h0, 1'b1, 4'b0000, 1'b0, 32'h600, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0100, 32'h0, 32'h0, 32'h621, 32'h0, 1'b1, 4'b0100, 1'b1, 32'h621, 2'd2));
    vecs.push_back(mk(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0100, 1'b0, 32'h621, 2'd2));

    // Power-on reset
    ARESET     = 1'b1;
    TVALID_IN  = 4'b0000;
    TDATA_IN   = '0;
    TREADY_OUT = 1'b1;
    @(posedge ACLK);
    @(posedge ACLK);
    #1;
    chk("reset tvalid_out", 32'(TVALID_OUT), 32'h0);
    chk("reset tdata_out", TDATA_OUT, 32'h0);
    chk("reset tid_out", 32'(TID_OUT), 32'h0);
    #4;
    chk("reset tready_in", 32'(TREADY_IN), 32'h0);
    @(posedge ACLK);
    #1;

    foreach (vecs[i]) apply(vecs[i], i);

    // All four requesters continuously valid; data 0x1i00 + beat number
    ARESET    = 1'b1;
    TVALID_IN = 4'b0000;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int c = 0; c < 25; c++) begin
      for (int i = 0; i < 4; i++)
        TDATA_IN[i*32 +: 32] = 32'h1000 + 32'(i) * 32'h100 + 32'(cnt[i]);
      TVALID_IN  = 4'b1111;
      TREADY_OUT = 1'b1;
      #4;
      hs = TREADY_IN;
      @(posedge ACLK);
      #1;
      // Cycle 5k is the arbitration bubble, 5k+1..5k+4 carry burst k
      exp_v = (c % 5) != 0;
      chk($sformatf("rr c%0d tvalid_out", c), 32'(TVALID_OUT), 32'(exp_v));
      if (exp_v) begin
        b = c / 5;
        j = (c % 5) - 1;
        r = b % 4;
        n = (b / 4) * 4 + j;
        chk($sformatf("rr c%0d tdata_out", c), TDATA_OUT, 32'h1000 + 32'(r) * 32'h100 + 32'(n));
        chk($sformatf("rr c%0d tid_out", c), 32'(TID_OUT), 32'(r));
      end
      for (int i = 0; i < 4; i++) if (hs[i]) cnt[i]++;
    end
    sum = cnt[0] + cnt[1] + cnt[2] + cnt[3];
    chk("rr accepted total", 32'(sum), 32'd20);
    chk("rr accepted req0", 32'(cnt[0]), 32'd8);
    TVALID_IN = 4'b0000;
    @(posedge ACLK);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
